// File: rtl/sram_like_arbiter_pkg.sv
// Shared definitions for the SRAM-like arbiter slice: transfer sizes,
// arbitration modes and the channel-index width helper.
package sram_like_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

  // Bits needed to name one of n channels; never less than one.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sram_like_arbiter_if.sv
// SRAM-like bus bundle. N request lanes share one payload/response set per
// lane group; the master side drives requests, the slave side answers.
import sram_like_pkg::*;

interface sram_like_arbiter_if #(
  parameter int unsigned N      = 1,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [N-1:0]              req;
  logic [N-1:0]              wr;
  logic [2*N-1:0]            size;
  logic [ADDR_W*N-1:0]       addr;
  logic [(DATA_W/8)*N-1:0]   wstrb;
  logic [DATA_W*N-1:0]       wdata;
  logic [N-1:0]              addr_ok;
  logic [N-1:0]              data_ok;
  logic [DATA_W-1:0]         rdata;

  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_like_id_fifo.sv
// In-order FIFO of channel IDs for transactions accepted by the slave.
// Caller guarantees no push when full and no pop when empty.
import sram_like_pkg::*;

module sram_like_id_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign head  = mem[rd_ptr];
  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);

  // Storage write; contents are don't-care until pushed, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// N-to-1 arbiter for the SRAM-like memory interface. Grants one master per
// cycle, holds the grant while a request is pending, and routes responses
// back in acceptance order using an ID FIFO.
import sram_like_pkg::*;

module sram_like_arbiter #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ARB_MODE   = ARB_FIXED
) (
  input  logic                          clk,
  input  logic                          resetn,
  sram_like_arbiter_if.slave            m,
  sram_like_arbiter_if.master           s,
  output logic [$clog2(FIFO_DEPTH):0]   outstanding,
  output logic                          resp_err
);
  localparam int unsigned CH_W = ch_width(NUM_CH);
  localparam int unsigned SW   = DATA_W / 8;

  typedef enum logic {
    ST_OPEN,
    ST_LOCKED
  } lock_state_t;

  lock_state_t      state, state_nxt;
  logic [CH_W-1:0]  lock_ch;
  logic [CH_W-1:0]  rr_ptr;
  logic [CH_W-1:0]  grant_arb;
  logic [CH_W-1:0]  grant;
  logic             s_req_i;
  logic             hs;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic [CH_W-1:0]  fifo_head;

  // Free arbitration: fixed scans from 0, round robin scans from rr_ptr.
  always_comb begin
    logic        found;
    int unsigned idx;
    grant_arb = '0;
    found     = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (ARB_MODE == ARB_RR) idx = (int'(rr_ptr) + k) % NUM_CH;
      else                    idx = k;
      if (!found && m.req[idx]) begin
        grant_arb = CH_W'(idx);
        found     = 1'b1;
      end
    end
  end

  // Lock FSM next state plus grant and slave request/handshake.
  always_comb begin
    state_nxt = state;
    grant     = (state == ST_LOCKED) ? lock_ch : grant_arb;
    s_req_i   = m.req[grant] & ~fifo_full;
    hs        = s_req_i & s.addr_ok[0];
    if (hs)           state_nxt = ST_OPEN;
    else if (s_req_i) state_nxt = ST_LOCKED;
  end

  // Lock state register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_OPEN;
    else         state <= state_nxt;
  end

  // Remember which channel owns the pending request.
  always_ff @(posedge clk) begin
    if (!resetn)                      lock_ch <= '0;
    else if (s_req_i && !s.addr_ok[0]) lock_ch <= grant;
  end

  // Round-robin pointer moves past the channel just accepted.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rr_ptr <= '0;
    end else if (ARB_MODE == ARB_RR && hs) begin
      rr_ptr <= (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
    end
  end

  // Sticky error for responses that match no outstanding transaction.
  always_ff @(posedge clk) begin
    if (!resetn)                       resp_err <= 1'b0;
    else if (s.data_ok[0] && fifo_empty) resp_err <= 1'b1;
  end

  // Slave payload mux from the granted channel.
  always_comb begin
    s.req[0] = s_req_i;
    s.wr     = '0;
    s.size   = '0;
    s.addr   = '0;
    s.wstrb  = '0;
    s.wdata  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (grant == CH_W'(i)) begin
        s.wr[0] = m.wr[i];
        s.size  = m.size[2*i +: 2];
        s.addr  = m.addr[ADDR_W*i +: ADDR_W];
        s.wstrb = m.wstrb[SW*i +: SW];
        s.wdata = m.wdata[DATA_W*i +: DATA_W];
      end
    end
  end

  assign pop = s.data_ok[0] & ~fifo_empty;

  // Per-channel accept and response strobes; read data is shared.
  always_comb begin
    m.addr_ok = '0;
    m.data_ok = '0;
    m.rdata   = s.rdata;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      m.addr_ok[i] = hs  && (grant == CH_W'(i));
      m.data_ok[i] = pop && (fifo_head == CH_W'(i));
    end
  end

  sram_like_id_fifo #(
    .WIDTH (CH_W),
    .DEPTH (FIFO_DEPTH)
  ) u_id_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (hs),
    .pop    (pop),
    .din    (grant),
    .head   (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (outstanding)
  );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench: a 2-channel fixed-priority instance and a 3-channel
// round-robin instance, checked against hand-computed values.
import sram_like_pkg::*;

module tb_sram_like_arbiter;
  logic clk = 1'b0;
  logic resetn;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sram_like_arbiter_if #(.N(2), .ADDR_W(32), .DATA_W(32)) fx_m ();
  sram_like_arbiter_if #(.N(1), .ADDR_W(32), .DATA_W(32)) fx_s ();
  sram_like_arbiter_if #(.N(3), .ADDR_W(32), .DATA_W(32)) rr_m ();
  sram_like_arbiter_if #(.N(1), .ADDR_W(32), .DATA_W(32)) rr_s ();

  logic [2:0] fx_out, rr_out;
  logic       fx_err, rr_err;

  sram_like_arbiter #(
    .NUM_CH(2), .ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(4), .ARB_MODE(ARB_FIXED)
  ) dut_fx (
    .clk(clk), .resetn(resetn), .m(fx_m), .s(fx_s),
    .outstanding(fx_out), .resp_err(fx_err)
  );

  sram_like_arbiter #(
    .NUM_CH(3), .ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(4), .ARB_MODE(ARB_RR)
  ) dut_rr (
    .clk(clk), .resetn(resetn), .m(rr_m), .s(rr_s),
    .outstanding(rr_out), .resp_err(rr_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge, then let inputs settle.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    resetn = 1'b0;
    fx_m.req = '0; fx_m.wr = 2'b10; fx_m.size = {SIZE_WORD, SIZE_HALF};
    fx_m.addr = {32'h0000_2000, 32'h0000_1000};
    fx_m.wstrb = {4'hF, 4'h3};
    fx_m.wdata = {32'h5555_1111, 32'hAAAA_0000};
    fx_s.addr_ok = '0; fx_s.data_ok = '0; fx_s.rdata = '0;
    rr_m.req = '0; rr_m.wr = '0; rr_m.size = '0; rr_m.wstrb = '0;
    rr_m.addr = {32'h300, 32'h200, 32'h100}; rr_m.wdata = '0;
    rr_s.addr_ok = '0; rr_s.data_ok = '0; rr_s.rdata = '0;

    tick(); tick();
    resetn = 1'b1;
    #1;
    check("rst_s_req", fx_s.req, 0);
    check("rst_out", fx_out, 0);
    check("rst_addr_ok", fx_m.addr_ok, 0);
    check("rst_data_ok", fx_m.data_ok, 0);
    check("rst_err", fx_err, 0);

    // Both channels request together: ch0 first, then ch1.
    fx_m.req = 2'b11; fx_s.addr_ok = 1'b1; #1;
    check("fix_s_req", fx_s.req, 1);
    check("fix_addr0", fx_s.addr, 32'h1000);
    check("fix_size0", fx_s.size, SIZE_HALF);
    check("fix_aok0", fx_m.addr_ok, 2'b01);
    tick();
    check("fix_out1", fx_out, 1);
    fx_m.req = 2'b10; #1;
    check("fix_addr1", fx_s.addr, 32'h2000);
    check("fix_wstrb1", fx_s.wstrb, 4'hF);
    check("fix_aok1", fx_m.addr_ok, 2'b10);
    tick();
    check("fix_out2", fx_out, 2);
    fx_m.req = '0; fx_s.addr_ok = 1'b0;
    fx_s.data_ok = 1'b1; fx_s.rdata = 32'hDEAD_0001; #1;
    check("fix_dok0", fx_m.data_ok, 2'b01);
    check("fix_rdata0", fx_m.rdata, 32'hDEAD_0001);
    tick();
    check("fix_out3", fx_out, 1);
    fx_s.rdata = 32'hDEAD_0002; #1;
    check("fix_dok1", fx_m.data_ok, 2'b10);
    check("fix_rdata1", fx_m.rdata, 32'hDEAD_0002);
    tick();
    check("fix_out4", fx_out, 0);
    fx_s.data_ok = 1'b0;

    // Lock: ch1 pending three cycles, ch0 joins, ch1 must keep the bus.
    fx_m.req = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("lock_addr_pend", fx_s.addr, 32'h2000);
      check("lock_aok_pend", fx_m.addr_ok, 0);
      tick();
    end
    fx_m.req = 2'b11; #1;
    check("lock_addr_held", fx_s.addr, 32'h2000);
    check("lock_wdata_held", fx_s.wdata, 32'h5555_1111);
    check("lock_s_wr", fx_s.wr, 1);
    tick();
    fx_s.addr_ok = 1'b1; #1;
    check("lock_aok_ch1", fx_m.addr_ok, 2'b10);
    tick();
    fx_m.req = 2'b01; #1;
    check("lock_aok_ch0", fx_m.addr_ok, 2'b01);
    tick();
    check("lock_out", fx_out, 2);
    fx_m.req = '0; fx_s.addr_ok = 1'b0; fx_s.data_ok = 1'b1; #1;
    check("lock_dok_ch1", fx_m.data_ok, 2'b10);
    tick();
    check("lock_dok_ch0", fx_m.data_ok, 2'b01);
    tick();
    fx_s.data_ok = 1'b0;
    check("lock_out_done", fx_out, 0);

    // Full FIFO: four accepts, then a pop frees a slot one cycle later.
    fx_m.req = 2'b01; fx_s.addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("full_aok", fx_m.addr_ok, 2'b01);
      tick();
    end
    check("full_out", fx_out, 4);
    check("full_s_req", fx_s.req, 0);
    check("full_aok_blk", fx_m.addr_ok, 0);
    fx_s.data_ok = 1'b1; #1;
    check("full_pop_dok", fx_m.data_ok, 2'b01);
    check("full_same_cyc_req", fx_s.req, 0);
    check("full_same_cyc_aok", fx_m.addr_ok, 0);
    tick();
    fx_s.data_ok = 1'b0; #1;
    check("full_next_req", fx_s.req, 1);
    check("full_next_aok", fx_m.addr_ok, 2'b01);
    tick();
    check("full_out_again", fx_out, 4);
    fx_m.req = '0; fx_s.addr_ok = 1'b0; fx_s.data_ok = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    fx_s.data_ok = 1'b0;
    check("full_drained", fx_out, 0);

    // Spurious response with nothing outstanding.
    fx_s.data_ok = 1'b1; #1;
    check("spur_dok", fx_m.data_ok, 0);
    tick();
    fx_s.data_ok = 1'b0;
    check("spur_err", fx_err, 1);
    check("spur_out", fx_out, 0);
    tick();
    check("spur_err_sticky", fx_err, 1);
    resetn = 1'b0; tick(); resetn = 1'b1;
    check("spur_err_clr", fx_err, 0);

    // Reset with two transactions in flight.
    fx_m.req = 2'b01; fx_s.addr_ok = 1'b1;
    tick(); tick();
    check("mid_out2", fx_out, 2);
    fx_m.req = '0; fx_s.addr_ok = 1'b0;
    resetn = 1'b0; tick(); resetn = 1'b1;
    check("mid_out0", fx_out, 0);
    check("mid_err0", fx_err, 0);
    fx_s.data_ok = 1'b1; #1;
    check("mid_dok", fx_m.data_ok, 0);
    tick();
    fx_s.data_ok = 1'b0;
    check("mid_err1", fx_err, 1);

    // Round robin, three channels always requesting.
    begin
      logic [2:0] exp_aok [6];
      exp_aok = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      rr_m.req = 3'b111; rr_s.addr_ok = 1'b1;
      for (int i = 0; i < 6; i++) begin
        rr_s.data_ok = (i > 0); #1;
        check("rr_aok", rr_m.addr_ok, exp_aok[i]);
        if (i > 0) check("rr_dok", rr_m.data_ok, exp_aok[i-1]);
        tick();
      end
      rr_m.req = '0; rr_s.addr_ok = 1'b0; rr_s.data_ok = 1'b1; #1;
      check("rr_dok_last", rr_m.data_ok, 3'b100);
      tick();
      rr_s.data_ok = 1'b0;
      check("rr_out", rr_out, 0);
      check("rr_err", rr_err, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
